wishbone_spi_controller: RTL and testbench
==========================================

WISHBONE_SPI_CONTROLLER -- requirements
Module: wishbone_spi_controller

Interface
REQ-001 SHALL have parameter DIV_RST, default 8'd4, reset value of the SCK divider field CTRL[15:8].
REQ-002 SHALL have port clk_i, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port wb_cyc_i, input, 1, decoded SPI cycle select from the Wishbone master.
REQ-005 SHALL have port wb_stb_i, input, 1, Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1, write enable.
REQ-007 SHALL have port wb_sel_i, input, 4, byte lane selects.
REQ-008 SHALL have port wb_adr_i, input, 2, word address (bus address bits [3:2]).
REQ-009 SHALL have port wb_dat_i, input, 32, write data.
REQ-010 SHALL have port wb_ack_o, output, 1, access acknowledge.
REQ-011 SHALL have port wb_dat_o, output, 32, read data.
REQ-012 SHALL have port spi_miso_i, input, 1, serial data in.
REQ-013 SHALL have port spi_mosi_o, output, 1, serial data out.
REQ-014 SHALL have port spi_sck_o, output, 1, serial clock.
REQ-015 SHALL have port spi_cs_o, output, 1, chip select, active-low.

Function
REQ-016 Register map: adr 0 = DATA, adr 1 = STATUS (bit0 busy, bit1 rx_valid; read-only), adr 2 = CTRL (bit0 cs_en, bits[15:8] div); adr 3 reads 0 and ignores writes.
REQ-017 wb_ack_o SHALL pulse high for exactly one cycle, in the cycle after the first cycle of wb_cyc_i&wb_stb_i, with no second ack while stb stays high through that ack cycle.
REQ-018 wb_dat_o SHALL be registered, valid in the ack cycle, and zero-extended; DATA reads return the rx byte in [7:0].
REQ-019 A DATA read SHALL clear rx_valid in its ack cycle.
REQ-020 A DATA write with wb_sel_i[0]=1 while idle SHALL load wb_dat_i[7:0] into the shift register and enter SHIFT in the ack cycle; busy reads 1 from the next cycle.
REQ-021 A DATA write while busy, or with wb_sel_i[0]=0, SHALL be acked and discarded.
REQ-022 A CTRL write SHALL update bit0 when sel[0]=1 and bits[15:8] when sel[1]=1; it takes effect immediately, including mid-transfer.
REQ-023 spi_cs_o SHALL equal ~cs_en at all times; the controller never drives CS autonomously.
REQ-024 SPI mode 0: SCK idles low, MSB first, MOSI presents bit 7 when SHIFT is entered.
REQ-025 Half-period counter: SCK SHALL toggle every div+1 clk cycles in SHIFT; div=0 gives SCK = clk/2.
REQ-026 On each SCK rising edge MISO SHALL be sampled into the LSB; on each falling edge the register shifts and MOSI presents the next bit.
REQ-027 States: IDLE -> SHIFT on an accepted DATA write; SHIFT -> DONE after the 8th falling edge (16 toggles); DONE -> IDLE after one cycle.
REQ-028 A transfer SHALL last 16*(div+1) cycles from SHIFT entry to DONE.
REQ-029 In DONE, the rx byte SHALL be latched, rx_valid set, and busy cleared.
REQ-030 If a DATA read ack and a DONE cycle coincide, rx_valid SHALL end set, with the new byte.
REQ-031 In IDLE, spi_mosi_o SHALL hold the last driven bit and spi_sck_o SHALL be 0.

Reset
REQ-032 On rst_n_i low, asynchronously: state IDLE, wb_ack_o=0, wb_dat_o=0, busy=0, rx_valid=0, rx byte=0, cs_en=0 (spi_cs_o=1), div=DIV_RST, spi_sck_o=0, spi_mosi_o=0, counters 0.
REQ-033 Reset asserted mid-transfer SHALL abort it with no rx_valid set; the first post-reset access SHALL behave as after power-up.

Verification
REQ-034 Reset release then read STATUS and CTRL -> 0x0 and 0x0400; spi_cs_o=1, spi_sck_o=0.
REQ-035 Write CTRL=0x0001 (sel=0011), then DATA=0xA5 with MISO looped to MOSI -> MOSI bits 1,0,1,0,0,1,0,1; 8 SCK pulses over 80 cycles; STATUS=0x2; DATA read=0xA5; STATUS then reads 0x0.
REQ-036 Write CTRL div=0, then DATA=0x3C while MISO is tied 1 -> SCK = clk/2, transfer takes 16 cycles, rx=0xFF.
REQ-037 Write DATA=0x11 then DATA=0x22 while busy -> both acked, MOSI carries 0x11 only.
REQ-038 Hold stb 3 cycles on a STATUS read -> exactly one ack pulse.
REQ-039 Assert rst_n_i after the 4th SCK edge of a transfer -> all outputs at reset values immediately; STATUS=0x0 after release.

Source files
------------

// File: rtl/wishbone_spi_controller.sv
// Wishbone-slave SPI master (mode 0, MSB first, 8-bit frames).
// Three registers: DATA (tx load / rx byte), STATUS (busy, rx_valid) and
// CTRL (software chip select, SCK half-period divider). Chip select is
// purely software driven. A transfer takes 16*(div+1) clocks.
module wishbone_spi_controller #(
   parameter logic [7:0] DIV_RST = 8'd4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [1:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   input  logic        spi_miso_i,
   output logic        spi_mosi_o,
   output logic        spi_sck_o,
   output logic        spi_cs_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] ADR_DATA   = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_CTRL   = 2'd2;

   state_t      state;
   logic        served;
   logic        busy;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        cs_en;
   logic [7:0]  div;
   logic [7:0]  sreg;
   logic        miso_q;
   logic [7:0]  cnt;
   logic [3:0]  tog;
   logic [31:0] rdata;

   logic req;
   logic acc;
   logic data_rd;
   logic data_wr;
   logic start;
   logic ctrl_wr;
   logic half_done;

   // Upper write-data bits and upper byte lanes have no register behind them.
   logic unused_bits;
   assign unused_bits = ^{wb_dat_i[31:16], wb_sel_i[3:2]};

   assign req = wb_cyc_i & wb_stb_i;
   // Accept only the first cycle of a strobe; "served" blocks a repeat ack
   // while the master keeps stb high past the ack cycle.
   assign acc     = req & ~wb_ack_o & ~served;
   assign data_rd = acc & ~wb_we_i & (wb_adr_i == ADR_DATA);
   assign data_wr = acc & wb_we_i & (wb_adr_i == ADR_DATA) & wb_sel_i[0];
   assign start   = data_wr & ~busy;
   assign ctrl_wr = acc & wb_we_i & (wb_adr_i == ADR_CTRL);

   // Compare with >= so lowering div mid-transfer below the running count
   // toggles on the next cycle instead of wrapping the counter.
   assign half_done = (cnt >= div);

   assign spi_cs_o = ~cs_en;

   // Read data mux, zero-extended.
   always_comb begin
      rdata = 32'd0;
      case (wb_adr_i)
         ADR_DATA:   rdata = {24'd0, rx_byte};
         ADR_STATUS: rdata = {30'd0, rx_valid, busy};
         ADR_CTRL:   rdata = {16'd0, div, 7'd0, cs_en};
         default:    rdata = 32'd0;
      endcase
   end

   // Bus side: single-cycle ack, registered read data, CTRL register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wb_ack_o <= 1'b0;
         served   <= 1'b0;
         wb_dat_o <= 32'd0;
         cs_en    <= 1'b0;
         div      <= DIV_RST;
      end else begin
         wb_ack_o <= acc;
         served   <= req & (served | wb_ack_o);
         if (acc) begin
            wb_dat_o <= rdata;
         end
         if (ctrl_wr) begin
            if (wb_sel_i[0]) cs_en <= wb_dat_i[0];
            if (wb_sel_i[1]) div   <= wb_dat_i[15:8];
         end
      end
   end

   // Transfer FSM: SCK generation, shift register, rx capture and status.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         busy       <= 1'b0;
         rx_valid   <= 1'b0;
         rx_byte    <= 8'd0;
         sreg       <= 8'd0;
         miso_q     <= 1'b0;
         cnt        <= 8'd0;
         tog        <= 4'd0;
         spi_sck_o  <= 1'b0;
         spi_mosi_o <= 1'b0;
      end else begin
         // A DATA read clears rx_valid; a coincident DONE below overrides it.
         if (data_rd) rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               spi_sck_o <= 1'b0;
               if (start) begin
                  sreg       <= wb_dat_i[7:0];
                  spi_mosi_o <= wb_dat_i[7];
                  cnt        <= 8'd0;
                  tog        <= 4'd0;
                  busy       <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (half_done) begin
                  cnt       <= 8'd0;
                  spi_sck_o <= ~spi_sck_o;
                  tog       <= tog + 4'd1;
                  if (!spi_sck_o) begin
                     // Rising edge: hold the sample until the falling edge so
                     // the untransmitted LSB of sreg is not overwritten.
                     miso_q <= spi_miso_i;
                  end else begin
                     sreg <= {sreg[6:0], miso_q};
                     if (tog == 4'd15) begin
                        // Last falling edge: MOSI keeps bit 0 into IDLE.
                        state <= DONE;
                     end else begin
                        spi_mosi_o <= sreg[6];
                     end
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               rx_byte  <= sreg;
               rx_valid <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_spi_controller.sv
// Directed bench for wishbone_spi_controller. Stimulus pushes expected read
// data and expected SPI frames into queues; two monitors pop and compare when
// the DUT acks a bus cycle or completes an SPI frame.
module tb_wishbone_spi_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_stb = 1'b0;
   logic        wb_we = 1'b0;
   logic [3:0]  wb_sel = 4'd0;
   logic [1:0]  wb_adr = 2'd0;
   logic [31:0] wb_dat_w = 32'd0;
   logic        wb_ack;
   logic [31:0] wb_dat_r;
   logic        spi_miso;
   logic        spi_mosi;
   logic        spi_sck;
   logic        spi_cs;
   logic        loop_en = 1'b0;
   logic        miso_val = 1'b0;

   assign spi_miso = loop_en ? spi_mosi : miso_val;

   always #5 clk = ~clk;

   wishbone_spi_controller #(.DIV_RST(8'd4)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .wb_cyc_i   (wb_cyc),
      .wb_stb_i   (wb_stb),
      .wb_we_i    (wb_we),
      .wb_sel_i   (wb_sel),
      .wb_adr_i   (wb_adr),
      .wb_dat_i   (wb_dat_w),
      .wb_ack_o   (wb_ack),
      .wb_dat_o   (wb_dat_r),
      .spi_miso_i (spi_miso),
      .spi_mosi_o (spi_mosi),
      .spi_sck_o  (spi_sck),
      .spi_cs_o   (spi_cs)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int ack_cyc = 0;
   int t_start = 0;
   int xfers = 0;
   int nrise = 0;
   int nfall = 0;
   logic [7:0] bits = 8'd0;
   logic sck_prev = 1'b0;

   logic [32:0] exp_q[$];
   string       name_q[$];
   logic [7:0]  mosi_q[$];
   int          len_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Bus monitor: every ack consumes one expected entry.
   initial begin : wb_mon
      logic [32:0] e;
      string nm;
      forever begin
         @(negedge clk);
         if (rst_n && wb_ack) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_ack: got ack with no access pending");
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (e[32]) chk(nm, wb_dat_r, e[31:0]);
            end
         end
      end
   end

   // SPI monitor: sample MOSI on SCK rise, close the frame on the 8th fall.
   initial begin : spi_mon
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            nrise = 0;
            nfall = 0;
            bits = 8'd0;
            sck_prev = 1'b0;
         end else begin
            if (spi_sck && !sck_prev) begin
               bits = {bits[6:0], spi_mosi};
               nrise++;
            end
            if (!spi_sck && sck_prev) begin
               nfall++;
               if (nfall == 8) begin
                  if (mosi_q.size() == 0) begin
                     nvec++;
                     nerr++;
                     $display("FAIL unexpected_xfer: got frame 0x%02h with none expected", bits);
                  end else begin
                     chk("mosi_byte", {24'd0, bits}, {24'd0, mosi_q.pop_front()});
                     chk("xfer_len", cyc - t_start, len_q.pop_front());
                     chk("sck_pulses", nrise, 32'd8);
                  end
                  nrise = 0;
                  nfall = 0;
                  xfers++;
               end
            end
            sck_prev = spi_sck;
         end
      end
   end

   task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input logic check, input logic [31:0] exp,
                          input string nm, input int hold);
      int n;
      exp_q.push_back({check, exp});
      name_q.push_back(nm);
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack && n < 20);
      if (!wb_ack) begin
         nvec++;
         nerr++;
         $display("FAIL ack_timeout %s: got no ack within 20 cycles, expected one", nm);
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end
      ack_cyc = cyc;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string nm);
      wb_xfer(1'b0, adr, 4'hF, 32'd0, 1'b1, exp, nm, 0);
   endtask

   task automatic wr(input logic [1:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      wb_xfer(1'b1, adr, sel, dat, 1'b0, 32'd0, "write", 0);
   endtask

   // Start a transfer that the SPI monitor is told to expect.
   task automatic xmit(input logic [7:0] b, input int len);
      mosi_q.push_back(b);
      len_q.push_back(len);
      wr(2'd0, 4'hF, {24'd0, b});
      t_start = ack_cyc;
   endtask

   task automatic wait_xfer(input int target);
      int n;
      n = 0;
      while (xfers < target && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (xfers < target) begin
         nvec++;
         nerr++;
         $display("FAIL xfer_timeout: got %0d frames expected %0d", xfers, target);
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'd0, wb_ack}, 32'd0);
      chk("rst_dat", wb_dat_r, 32'd0);
      chk("rst_cs", {31'd0, spi_cs}, 32'd1);
      chk("rst_sck", {31'd0, spi_sck}, 32'd0);
      chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(2'd1, 32'h0, "status_rst");
      rd(2'd2, 32'h0400, "ctrl_rst");

      // cs_en only (div stays at 4), loopback frame 0xA5
      wr(2'd2, 4'b0001, 32'h0000_0001);
      #1 chk("cs_on", {31'd0, spi_cs}, 32'd0);
      loop_en = 1'b1;
      xmit(8'hA5, 80);
      wait_xfer(1);
      chk("mosi_idle_hold", {31'd0, spi_mosi}, 32'd1);
      rd(2'd1, 32'h2, "status_rxv");
      rd(2'd0, 32'hA5, "data_a5");
      rd(2'd1, 32'h0, "status_clr");

      // div only (sel lane 1): cs_en must survive, SCK = clk/2
      loop_en = 1'b0;
      miso_val = 1'b1;
      wr(2'd2, 4'b0010, 32'h0000_0000);
      rd(2'd2, 32'h0001, "ctrl_div0");
      xmit(8'h3C, 16);
      wait_xfer(2);
      rd(2'd1, 32'h2, "status_rxv2");
      rd(2'd0, 32'hFF, "data_ff");

      // Second write while busy is discarded
      xmit(8'h11, 16);
      wr(2'd0, 4'hF, 32'h22);
      wait_xfer(3);
      rd(2'd0, 32'hFF, "data_11");
      repeat (20) @(posedge clk);
      chk("no_extra_xfer", xfers, 32'd3);

      // DATA write without lane 0 is discarded
      wr(2'd0, 4'b1110, 32'h55);
      rd(2'd1, 32'h0, "status_nosel");

      // STATUS is read-only, adr 3 reads zero
      wr(2'd1, 4'hF, 32'hFFFF_FFFF);
      rd(2'd1, 32'h0, "status_ro");
      wr(2'd3, 4'hF, 32'hFFFF_FFFF);
      rd(2'd3, 32'h0, "adr3");

      // Held strobe yields a single ack
      wb_xfer(1'b0, 2'd1, 4'hF, 32'd0, 1'b1, 32'h0, "status_hold", 1);
      repeat (4) @(posedge clk);
      chk("hold_single_ack", exp_q.size(), 32'd0);

      // Reset after the 4th SCK edge aborts the transfer
      wr(2'd2, 4'b0011, 32'h0000_0401);
      wr(2'd0, 4'hF, 32'hFF);
      rd(2'd2, 32'h0401, "ctrl_401");
      n = 0;
      while (nrise + nfall < 4 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (nrise + nfall < 4) begin
         nvec++;
         nerr++;
         $display("FAIL edge_timeout: got %0d SCK edges expected 4", nrise + nfall);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ack", {31'd0, wb_ack}, 32'd0);
      chk("abort_dat", wb_dat_r, 32'd0);
      chk("abort_sck", {31'd0, spi_sck}, 32'd0);
      chk("abort_mosi", {31'd0, spi_mosi}, 32'd0);
      chk("abort_cs", {31'd0, spi_cs}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd(2'd1, 32'h0, "status_post");
      rd(2'd2, 32'h0400, "ctrl_post");
      rd(2'd0, 32'h0, "data_post");
      repeat (40) @(posedge clk);
      chk("abort_no_frame", xfers, 32'd3);
      chk("pending_reads", exp_q.size(), 32'd0);
      chk("pending_frames", mosi_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
